// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants shared by the sync generator and the
// downstream pixel/colour generator.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  localparam logic VGA_SYNC_POL = 1'b0;
  localparam int   VGA_CW       = 10;

endpackage

// File: rtl/vga_edge_tick.sv
// Rising-edge detector turning the divider's square wave into a one-cycle
// enable in the clk_i domain.
module vga_edge_tick (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic div_i,
  output logic tick_o
);

  logic div_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_i;
    end
  end

  assign tick_o = div_i & ~div_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator advancing on divider rising edges;
// all outputs are registered and decoded from the post-advance counter values.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter logic SYNC_POL  = VGA_SYNC_POL,
  parameter int   CW        = VGA_CW
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          div_frec,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          pix_tick,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic          tick;
  logic          h_wrap;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          frame_start_q, frame_start_d;
  logic          pix_tick_q;

  vga_edge_tick u_edge_tick (
    .clk_i  (clk_in),
    .rst_ni (reset),
    .div_i  (div_frec),
    .tick_o (tick)
  );

  // Out-of-range counts (>= TOTAL) collapse to 0 instead of counting on.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_wrap        = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      h_wrap = (h_cnt_q >= H_LAST);
      if (h_wrap) begin
        h_cnt_d = '0;
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
      if (v_cnt_q > V_LAST) begin
        v_cnt_d = '0;
      end else if (h_wrap) begin
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    hsync_d    = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
  end

  // Decoded outputs load only on ticks so the reset values persist until the
  // first advance, then track the counters they were decoded from.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= tick;
      frame_start_q <= frame_start_d;
      if (tick) begin
        h_cnt_q    <= h_cnt_d;
        v_cnt_q    <= v_cnt_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_on_d;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a full-size 640x480 instance plus a shrunken-timing
// instance so whole frames fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       div_frec;
  logic       b_hs, b_vs, b_von, b_pt, b_fs;
  logic [9:0] b_x, b_y;
  logic       s_hs, s_vs, s_von, s_pt, s_fs;
  logic [9:0] s_x, s_y;

  int n_chk = 0;
  int n_err = 0;

  exp_t q0[$];
  exp_t q1[$];

  // index 0 = full-size instance, index 1 = shrunken instance
  int hv_a  [2] = '{640, 8};
  int hf_a  [2] = '{16, 2};
  int hsw_a [2] = '{96, 3};
  int hb_a  [2] = '{48, 2};
  int vv_a  [2] = '{480, 6};
  int vf_a  [2] = '{10, 1};
  int vsw_a [2] = '{2, 2};
  int vb_a  [2] = '{33, 1};

  int   mh [2];
  int   mv [2];
  logic prev_div;
  bit   seen [2];
  int   win_ticks [2];
  int   hs_low [2];
  int   vs_low [2];
  int   von_low [2];
  int   hs_first [2];
  int   frames;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk_in      (clk),
    .reset       (reset),
    .div_frec    (div_frec),
    .hsync       (b_hs),
    .vsync       (b_vs),
    .video_on    (b_von),
    .pixel_x     (b_x),
    .pixel_y     (b_y),
    .pix_tick    (b_pt),
    .frame_start (b_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) dut_s (
    .clk_in      (clk),
    .reset       (reset),
    .div_frec    (div_frec),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_von),
    .pixel_x     (s_x),
    .pixel_y     (s_y),
    .pix_tick    (s_pt),
    .frame_start (s_fs)
  );

  task automatic check_eq(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int htot(input int i);
    return hv_a[i] + hf_a[i] + hsw_a[i] + hb_a[i];
  endfunction

  function automatic int vtot(input int i);
    return vv_a[i] + vf_a[i] + vsw_a[i] + vb_a[i];
  endfunction

  task automatic clear_window(input int i);
    win_ticks[i] = 0;
    hs_low[i]    = 0;
    vs_low[i]    = 0;
    von_low[i]   = 0;
    hs_first[i]  = -1;
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    prev_div = 1'b0;
    frames   = 0;
    for (int i = 0; i < 2; i++) begin
      mh[i]   = 0;
      mv[i]   = 0;
      seen[i] = 1'b0;
      clear_window(i);
    end
  endtask

  task automatic model_tick(input int i);
    exp_t e;
    int   hs0, vs0;
    e.fs = 1'b0;
    if (mh[i] == htot(i) - 1) begin
      mh[i] = 0;
      if (mv[i] == vtot(i) - 1) begin
        mv[i] = 0;
        e.fs  = 1'b1;
      end else begin
        mv[i] = mv[i] + 1;
      end
    end else begin
      mh[i] = mh[i] + 1;
    end
    hs0   = hv_a[i] + hf_a[i];
    vs0   = vv_a[i] + vf_a[i];
    e.x   = 10'(mh[i]);
    e.y   = 10'(mv[i]);
    e.hs  = (mh[i] >= hs0 && mh[i] < hs0 + hsw_a[i]) ? 1'b0 : 1'b1;
    e.vs  = (mv[i] >= vs0 && mv[i] < vs0 + vsw_a[i]) ? 1'b0 : 1'b1;
    e.von = (mh[i] < hv_a[i]) && (mv[i] < vv_a[i]);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // A rising edge on div_frec produces a tick on the following clock edge.
  task automatic drive(input logic d);
    @(posedge clk);
    #1;
    div_frec = d;
    if (d && !prev_div) begin
      model_tick(0);
      model_tick(1);
    end
    prev_div = d;
  endtask

  task automatic mon(input int i, input logic [9:0] x, input logic [9:0] y,
                     input logic hs, input logic vs, input logic von,
                     input logic pt, input logic fs);
    exp_t  e;
    int    qs, xi, yi, row, ht, vt;
    string p;
    p  = (i == 0) ? "big" : "small";
    xi = int'(x);
    yi = int'(y);
    ht = htot(i);
    vt = vtot(i);
    if (pt) begin
      qs = (i == 0) ? q0.size() : q1.size();
      check_eq({p, ".tick_expected"}, int'(qs > 0), 1);
      if (qs > 0) begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check_eq({p, ".pixel_x"},     xi, int'(e.x));
        check_eq({p, ".pixel_y"},     yi, int'(e.y));
        check_eq({p, ".hsync"},       int'(hs), int'(e.hs));
        check_eq({p, ".vsync"},       int'(vs), int'(e.vs));
        check_eq({p, ".video_on"},    int'(von), int'(e.von));
        check_eq({p, ".frame_start"}, int'(fs), int'(e.fs));
      end
      seen[i]      = 1'b1;
      win_ticks[i] = win_ticks[i] + 1;
      if (!hs) begin
        hs_low[i] = hs_low[i] + 1;
        if (hs_first[i] < 0) hs_first[i] = xi;
      end
      if (!vs)  vs_low[i]  = vs_low[i] + 1;
      if (!von) von_low[i] = von_low[i] + 1;
      if (i == 0 && xi == 0) begin
        row = (yi == 0) ? vt - 1 : yi - 1;
        check_eq("big.line_ticks", win_ticks[0], ht);
        check_eq("big.hsync_low_ticks", hs_low[0], hsw_a[0]);
        check_eq("big.hsync_first_x", hs_first[0], hv_a[0] + hf_a[0]);
        check_eq("big.video_off_ticks", von_low[0],
                 ((row < vv_a[0]) ? ht - hv_a[0] : ht - 1) + ((yi < vv_a[0]) ? 0 : 1));
        clear_window(0);
      end
      if (i == 1 && fs) begin
        check_eq("small.frame_ticks", win_ticks[1], ht * vt);
        check_eq("small.vsync_low_ticks", vs_low[1], vsw_a[1] * ht);
        frames = frames + 1;
        clear_window(1);
      end
    end else begin
      check_eq({p, ".frame_start_idle"}, int'(fs), 0);
    end
    if (seen[i]) begin
      check_eq({p, ".video_on_inv"}, int'(von), int'(xi < hv_a[i] && yi < vv_a[i]));
      check_eq({p, ".x_range"}, int'(xi < ht), 1);
      check_eq({p, ".y_range"}, int'(yi < vt), 1);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, b_x, b_y, b_hs, b_vs, b_von, b_pt, b_fs);
      mon(1, s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs);
    end
  end

  task automatic check_idle(input string p);
    check_eq({p, ".big.x"},      int'(b_x), 0);
    check_eq({p, ".big.y"},      int'(b_y), 0);
    check_eq({p, ".big.hsync"},  int'(b_hs), 1);
    check_eq({p, ".big.vsync"},  int'(b_vs), 1);
    check_eq({p, ".big.von"},    int'(b_von), 0);
    check_eq({p, ".big.tick"},   int'(b_pt), 0);
    check_eq({p, ".big.fs"},     int'(b_fs), 0);
    check_eq({p, ".small.x"},    int'(s_x), 0);
    check_eq({p, ".small.y"},    int'(s_y), 0);
    check_eq({p, ".small.hsync"}, int'(s_hs), 1);
    check_eq({p, ".small.vsync"}, int'(s_vs), 1);
    check_eq({p, ".small.von"},  int'(s_von), 0);
    check_eq({p, ".small.tick"}, int'(s_pt), 0);
    check_eq({p, ".small.fs"},   int'(s_fs), 0);
  endtask

  task automatic release_reset(input string p);
    repeat (3) drive(1'b0);
    @(negedge clk);
    check_idle({p, ".in_reset"});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle({p, ".after_release"});
  endtask

  task automatic run_until(input int i, input int h, input int v, input string tag);
    int n;
    n = 0;
    while (!(mh[i] == h && mv[i] == v) && n < 4000) begin
      drive(~prev_div);
      n++;
    end
    check_eq({tag, ".reached"}, int'(mh[i] == h && mv[i] == v), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] sx, sy;
    logic       shs, svs;
    reset    = 1'b0;
    div_frec = 1'b0;
    reset_model();
    release_reset("por");

    run_until(0, 300, 1, "big_300_1");
    @(posedge clk);
    @(negedge clk);
    sx  = s_x;
    sy  = s_y;
    shs = s_hs;
    svs = s_vs;
    repeat (50) drive(1'b1);
    @(negedge clk);
    check_eq("hold.big.x", int'(b_x), 300);
    check_eq("hold.big.y", int'(b_y), 1);
    check_eq("hold.big.hsync", int'(b_hs), 1);
    check_eq("hold.big.tick", int'(b_pt), 0);
    check_eq("hold.small.x", int'(s_x), int'(sx));
    check_eq("hold.small.y", int'(s_y), int'(sy));
    check_eq("hold.small.hsync", int'(s_hs), int'(shs));
    check_eq("hold.small.vsync", int'(s_vs), int'(svs));

    run_until(1, 11, 8, "small_11_8");
    @(posedge clk);
    @(negedge clk);
    #2;
    check_eq("pre_rst.small.hsync", int'(s_hs), 0);
    check_eq("pre_rst.small.vsync", int'(s_vs), 0);
    reset = 1'b0;
    #1;
    check_idle("async_rst");
    reset_model();
    release_reset("rerun");

    repeat (620) drive(~prev_div);
    repeat (4) drive(1'b0);
    @(negedge clk);
    check_eq("drain.big_queue", q0.size(), 0);
    check_eq("drain.small_queue", q1.size(), 0);
    check_eq("small.frames_seen", int'(frames >= 2), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Consumes the pixel-rate square wave from the VGA clock divider and generates 640x480@60 Hz VGA timing in the system clock domain. Detects each rising edge of the divider output and uses it as a one-cycle pixel tick. Drives horizontal/vertical counters, sync pulses, the active-video flag and pixel coordinates for the downstream pixel/colour generator. Everything runs on clk_in; the divider output is used only as an enable, never as a clock.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync pulse width (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CW, 10, counter/coordinate width

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
div_frec  input  1  pixel-rate square wave from the VGA clock divider
hsync  output  1  horizontal sync, registered
vsync  output  1  vertical sync, registered
video_on  output  1  high while (h_cnt, v_cnt) is in the visible area
pixel_x  output  CW  current column (equals h_cnt)
pixel_y  output  CW  current row (equals v_cnt)
pix_tick  output  1  one-cycle strobe, high on cycles where the counters advance
frame_start  output  1  one-cycle strobe when counters wrap to (0,0)

Behaviour:
- H_TOTAL = sum of H_* (800). V_TOTAL = sum of V_* (525). Both must fit in CW bits.
- Edge detect: div_d <= div_frec every clk_in cycle. tick = div_frec & ~div_d. pix_tick is tick registered, so it lags tick by 1 cycle.
- Counters advance on a clk_in edge only when tick=1:
  - h_cnt wraps from H_TOTAL-1 to 0.
  - On the h wrap, v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0.
  - No arithmetic past TOTAL-1. Any counter value >= TOTAL is forced to 0 on the next tick.
- Registered outputs update on the same edge as the counters and are decoded from the new counter values, so they stay coherent with pixel_x/pixel_y:
  - hsync = SYNC_POL when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751), otherwise ~SYNC_POL.
  - vsync = SYNC_POL when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491), otherwise ~SYNC_POL.
  - video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - frame_start = 1 for exactly one cycle on the edge where both counters become 0 through a wrap; 0 on every other cycle.
- Between ticks, all outputs hold their values, except pix_tick and frame_start, which return to 0.
- Reset (reset=0, asynchronous assert, synchronous release through flops):
  - div_d=0, h_cnt=0, v_cnt=0, pixel_x=0, pixel_y=0.
  - hsync=vsync=~SYNC_POL.
  - video_on=0, pix_tick=0, frame_start=0.
- First tick after reset: counters go to (1,0) and video_on goes to 1. frame_start is not asserted, because no wrap occurred.
- Reset asserted mid-line or mid-frame: immediate return to the reset values. Timing restarts from (0,0) without completing the current frame.
- div_frec held constant (0 or 1): no tick, so all state freezes. A glitch-free restart resumes from the frozen counters.
- div_frec high at reset release: div_d=0, so a tick fires on the first cycle. This is accepted behaviour.

Decomposition:
- A shared vga_timing_pkg holds the 640x480 timing constants, derived H_TOTAL/V_TOTAL and the sync start/end constants, for reuse by the pixel generator.
- One sub-module is natural: vga_edge_tick (div_d register plus rising-edge detect) producing tick, reused by other blocks that consume the divider output.
- Counters and decode stay in the top module.

Test Plan:
- Reset hold then release with div_frec toggling every clk_in cycle -> after reset, hsync=vsync=1, video_on=0 and (x,y)=(0,0); the first pix_tick shows (1,0) with video_on=1.
- Run one full line -> hsync low for exactly 96 ticks starting at pixel_x=656; video_on low from pixel_x=640 through 799; pixel_y increments when pixel_x wraps 799->0.
- Run one full frame -> vsync low for exactly 2 lines (pixel_y 490,491, i.e. 1600 ticks); frame_start pulses once after 420000 ticks (840000 clk_in cycles) and is 1 cycle wide.
- Hold div_frec at 1 for 50 cycles mid-line at (300,100) -> counters and sync outputs unchanged, pix_tick=0 throughout; counting resumes at (301,100).
- Assert reset at (700,491) (hsync and vsync both low) -> outputs immediately go to hsync=vsync=1, video_on=0, (0,0) with no clock required; the post-release sequence matches scenario 1.
- Bench checker: every cycle, video_on equals (pixel_x<640 && pixel_y<480), and pixel_x<800, pixel_y<525 hold across 2 frames.
